led_pattern_gen: RTL and testbench

Parametrised LED pattern generator for the iCEBreaker board top level. It derives a slow step tick from the board clock and shows Gray-count, binary-count or bouncing-scan patterns on `LEDS` outputs. Two raw push-buttons are synchronised and debounced inside the block: one cycles the display mode, the other pauses or resumes the animation. An optional PWM "breathe" mode can be compiled in.

---
 rtl/led_pattern_gen_pkg.sv | 45 ++++
 rtl/led_pattern_gen_if.sv | 34 +++
 rtl/led_pattern_gen_btn_debounce.sv | 59 +++++
 rtl/led_pattern_gen.sv | 175 +++++++++++++++++
 tb/tb_led_pattern_gen.sv | 381 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_pattern_gen_pkg.sv
// -----------------------------------------------------------------------------
// led_pattern_pkg
// Shared types and helpers for the LED pattern generator.
//   mode_t      : display mode encoding as seen on the `mode` output
//   MODE_LAST   : last mode in the press sequence (BREATHE when the macro
//                 LED_PATTERN_BREATHE_EN is defined, SCAN otherwise)
//   idx_width() : bits needed to index n items (never less than 1)
//   next_mode() : successor of a mode in the press sequence
// -----------------------------------------------------------------------------
package led_pattern_pkg;

   typedef enum logic [1:0] {
      GRAY    = 2'd0,
      BINARY  = 2'd1,
      SCAN    = 2'd2,
      BREATHE = 2'd3
   } mode_t;

`ifdef LED_PATTERN_BREATHE_EN
   localparam mode_t MODE_LAST = BREATHE;
`else
   localparam mode_t MODE_LAST = SCAN;
`endif

   function automatic int unsigned idx_width(input int unsigned n);
      int unsigned w;
      if (n <= 32'd1) begin
         w = 32'd1;
      end else begin
         w = $clog2(n);
      end
      return w;
   endfunction

   function automatic mode_t next_mode(input mode_t m);
      mode_t r;
      if (m == MODE_LAST) begin
         r = GRAY;
      end else begin
         r = mode_t'(m + 2'd1);
      end
      return r;
   endfunction

endpackage

// File: rtl/led_pattern_gen_if.sv
// -----------------------------------------------------------------------------
// led_pattern_gen_if
// Board-side signal bundle of the LED pattern generator.
//   btn_mode  : raw mode button, active-high, asynchronous
//   btn_pause : raw pause button, active-high, asynchronous
//   led       : registered LED drive, active-high
//   mode      : current display mode
// Modports: master = board / stimulus side, slave = the generator.
// -----------------------------------------------------------------------------
interface led_pattern_gen_if #(
   parameter int LEDS = 5
);
   import led_pattern_pkg::*;

   logic            btn_mode;
   logic            btn_pause;
   logic [LEDS-1:0] led;
   mode_t           mode;

   modport master (
      output btn_mode,
      output btn_pause,
      input  led,
      input  mode
   );

   modport slave (
      input  btn_mode,
      input  btn_pause,
      output led,
      output mode
   );

endinterface

// File: rtl/led_pattern_gen_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Synchronises one raw push-button, filters bounce and emits a single-cycle
// pulse when the filtered level rises.
//   clk    : board clock
//   resetn : asynchronous active-low reset
//   raw    : raw button, asynchronous to clk
//   level  : debounced button level
//   press  : one-cycle pulse on a debounced rising edge
// A new level is accepted only after the synchronised input has disagreed
// with the current level for 2^DEBOUNCE_LOG2 consecutive cycles.
// -----------------------------------------------------------------------------
module btn_debounce
   import led_pattern_pkg::*;
#(
   parameter int DEBOUNCE_LOG2 = 16
) (
   input  logic clk,
   input  logic resetn,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam logic [DEBOUNCE_LOG2-1:0] CNT_INC = DEBOUNCE_LOG2'(1);

   logic [1:0]               sync_r;
   logic [DEBOUNCE_LOG2-1:0] cnt_r;
   logic                     level_r;
   logic                     press_r;

   // Synchroniser, stability counter, debounced level and press pulse.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync_r  <= 2'b00;
         cnt_r   <= '0;
         level_r <= 1'b0;
         press_r <= 1'b0;
      end else begin
         sync_r  <= {sync_r[0], raw};
         press_r <= 1'b0;
         if (sync_r[1] == level_r) begin
            // Input agrees with the accepted level: any partial run is lost.
            cnt_r <= '0;
         end else if (&cnt_r) begin
            // Disagreement has now lasted the full window.
            level_r <= sync_r[1];
            cnt_r   <= '0;
            press_r <= sync_r[1];
         end else begin
            cnt_r <= cnt_r + CNT_INC;
         end
      end
   end

   assign level = level_r;
   assign press = press_r;

endmodule

// File: rtl/led_pattern_gen.sv
// -----------------------------------------------------------------------------
// led_pattern_gen
// Slow LED animation for the iCEBreaker top level: Gray count, binary count,
// bouncing one-hot scan and (optionally) a PWM breathe mode.
//   clk            : board clock (after the global buffer)
//   resetn         : asynchronous active-low reset, release pre-synchronised
//   io.btn_mode    : raw button, cycles the display mode
//   io.btn_pause   : raw button, pauses / resumes the animation
//   io.led         : registered LED drive, active-high
//   io.mode        : current mode (0 GRAY, 1 BINARY, 2 SCAN, 3 BREATHE)
// Build option: define LED_PATTERN_BREATHE_EN to add mode 3 (BREATHE) with
// its PWM counter and brightness ramp; otherwise none of it is built.
// -----------------------------------------------------------------------------
module led_pattern_gen
   import led_pattern_pkg::*;
#(
   parameter int LEDS          = 5,
   parameter int LOG2DELAY     = 22,
   parameter int DEBOUNCE_LOG2 = 16,
   parameter int PWM_BITS      = 8
) (
   input  logic             clk,
   input  logic             resetn,
   led_pattern_gen_if.slave io
);

   localparam int POS_W = idx_width(LEDS);

   localparam logic [LOG2DELAY-1:0] PRE_INC   = LOG2DELAY'(1);
   localparam logic [LEDS-1:0]      STEP_INC  = LEDS'(1);
   localparam logic [LEDS-1:0]      LED_ONE   = LEDS'(1);
   localparam logic [POS_W-1:0]     POS_INC   = POS_W'(1);
   // Position from which one more step up lands on the top LED.
   localparam logic [POS_W-1:0]     POS_TURN  = POS_W'(LEDS - 2);

   if (LEDS < 2 || LOG2DELAY <= PWM_BITS) begin : g_param_check
      $error("led_pattern_gen: needs LEDS >= 2 and LOG2DELAY > PWM_BITS");
   end

   logic                 mode_press_s;
   logic                 pause_press_s;
   logic                 mode_level_unused_s;
   logic                 pause_level_unused_s;
   logic                 tick_s;
   logic [LEDS-1:0]      pattern_s;

   mode_t                mode_r;
   logic                 paused_r;
   logic [LOG2DELAY-1:0] pre_r;
   logic [LEDS-1:0]      step_r;
   logic [POS_W-1:0]     pos_r;
   logic                 dir_down_r;
   logic [LEDS-1:0]      led_r;

   btn_debounce #(.DEBOUNCE_LOG2(DEBOUNCE_LOG2)) u_btn_mode (
      .clk    (clk),
      .resetn (resetn),
      .raw    (io.btn_mode),
      .level  (mode_level_unused_s),
      .press  (mode_press_s)
   );

   btn_debounce #(.DEBOUNCE_LOG2(DEBOUNCE_LOG2)) u_btn_pause (
      .clk    (clk),
      .resetn (resetn),
      .raw    (io.btn_pause),
      .level  (pause_level_unused_s),
      .press  (pause_press_s)
   );

   assign tick_s = (&pre_r) & ~paused_r;

`ifdef LED_PATTERN_BREATHE_EN
   localparam logic [PWM_BITS-1:0] PWM_INC     = PWM_BITS'(1);
   localparam logic [PWM_BITS-1:0] BRIGHT_TOP  = {PWM_BITS{1'b1}} - PWM_INC;

   logic [PWM_BITS-1:0] pwm_r;
   logic [PWM_BITS-1:0] bright_r;
   logic                bright_down_r;
   logic                bright_tick_s;
   logic [LEDS-1:0]     breathe_led_s;

   // Brightness steps on the low prescaler bits, so it shares pause and clear.
   assign bright_tick_s = (&pre_r[LOG2DELAY-PWM_BITS-1:0]) & ~paused_r;
   assign breathe_led_s = {LEDS{pwm_r < bright_r}};

   // Free-running PWM counter and triangular brightness ramp.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pwm_r         <= '0;
         bright_r      <= '0;
         bright_down_r <= 1'b0;
      end else begin
         pwm_r <= pwm_r + PWM_INC;
         if (mode_press_s) begin
            bright_r      <= '0;
            bright_down_r <= 1'b0;
         end else if (bright_tick_s) begin
            if (bright_down_r) begin
               bright_r <= bright_r - PWM_INC;
               if (bright_r == PWM_INC) begin
                  bright_down_r <= 1'b0;
               end
            end else begin
               bright_r <= bright_r + PWM_INC;
               if (bright_r == BRIGHT_TOP) begin
                  bright_down_r <= 1'b1;
               end
            end
         end
      end
   end
`endif

   // Pattern selected by the current (registered) mode and animation state.
   always_comb begin
      pattern_s = '0;
      case (mode_r)
         GRAY:    pattern_s = step_r ^ (step_r >> 1'b1);
         BINARY:  pattern_s = step_r;
         SCAN:    pattern_s = LED_ONE << pos_r;
`ifdef LED_PATTERN_BREATHE_EN
         BREATHE: pattern_s = breathe_led_s;
`endif
         default: pattern_s = '0;
      endcase
   end

   // Mode FSM, pause flag, prescaler, step, scan position and LED register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mode_r     <= GRAY;
         paused_r   <= 1'b0;
         pre_r      <= '0;
         step_r     <= '0;
         pos_r      <= '0;
         dir_down_r <= 1'b0;
         led_r      <= '0;
      end else begin
         led_r <= pattern_s;
         if (pause_press_s) begin
            paused_r <= ~paused_r;
         end
         // A mode press restarts the animation even while paused.
         if (mode_press_s) begin
            mode_r     <= next_mode(mode_r);
            pre_r      <= '0;
            step_r     <= '0;
            pos_r      <= '0;
            dir_down_r <= 1'b0;
         end else if (!paused_r) begin
            pre_r <= pre_r + PRE_INC;
            if (tick_s) begin
               step_r <= step_r + STEP_INC;
               // Turn at the ends so each end LED is lit for a single tick.
               if (dir_down_r) begin
                  pos_r <= pos_r - POS_INC;
                  if (pos_r == POS_INC) begin
                     dir_down_r <= 1'b0;
                  end
               end else begin
                  pos_r <= pos_r + POS_INC;
                  if (pos_r == POS_TURN) begin
                     dir_down_r <= 1'b1;
                  end
               end
            end
         end
      end
   end

   assign io.led  = led_r;
   assign io.mode = mode_r;

endmodule

// File: tb/tb_led_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_gen
// Self-checking bench for led_pattern_gen with LEDS=5, LOG2DELAY=3,
// DEBOUNCE_LOG2=2, PWM_BITS=2. Expected LED values are queued when the
// stimulus is applied and popped when the design is due to show them.
// -----------------------------------------------------------------------------
module tb_led_pattern_gen;
   import led_pattern_pkg::*;

   localparam int LEDS          = 5;
   localparam int LOG2DELAY     = 3;
   localparam int DEBOUNCE_LOG2 = 2;
   localparam int PWM_BITS      = 2;

   logic clk = 1'b0;
   logic resetn;
   int   vectors     = 0;
   int   miscompares = 0;
   logic [LEDS-1:0] exp_q [$];

   led_pattern_gen_if #(.LEDS(LEDS)) io_if ();

   led_pattern_gen #(
      .LEDS          (LEDS),
      .LOG2DELAY     (LOG2DELAY),
      .DEBOUNCE_LOG2 (DEBOUNCE_LOG2),
      .PWM_BITS      (PWM_BITS)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .io     (io_if)
   );

   always #5 clk = ~clk;

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic adv(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [LEDS-1:0] gray_of(input int k);
      logic [LEDS-1:0] s;
      s = LEDS'(k);
      return s ^ (s >> 1);
   endfunction

   // Raw press held 4 cycles; returns on the edge where its effect appears.
   task automatic do_press(input logic m, input logic p);
      io_if.btn_mode  = m;
      io_if.btn_pause = p;
      adv(4);
      io_if.btn_mode  = 1'b0;
      io_if.btn_pause = 1'b0;
      adv(3);
   endtask

   task automatic test_reset;
      resetn          = 1'b0;
      io_if.btn_mode  = 1'b0;
      io_if.btn_pause = 1'b0;
      adv(3);
      vectors++;
      if (io_if.led !== 5'b00000) begin
         miscompares++;
         $display("FAIL reset_led: got %b expected %b", io_if.led, 5'b00000);
      end
      vectors++;
      if (io_if.mode !== 2'd0) begin
         miscompares++;
         $display("FAIL reset_mode: got %0d expected 0", io_if.mode);
      end
   endtask

   task automatic test_gray;
      int cur;
      logic [LEDS-1:0] e;
      @(posedge clk);
      #1;
      resetn = 1'b1;
      cur = 0;
      for (int k = 0; k <= 8; k++) exp_q.push_back(gray_of(k));
      for (int k = 0; k <= 8; k++) begin
         if (k > 0) begin
            adv(8 * k - cur);
            cur = 8 * k;
            vectors++;
            if (io_if.led !== gray_of(k - 1)) begin
               miscompares++;
               $display("FAIL gray_hold k=%0d: got %b expected %b", k, io_if.led, gray_of(k - 1));
            end
         end
         adv(8 * k + 1 - cur);
         cur = 8 * k + 1;
         e = exp_q.pop_front();
         vectors++;
         if (io_if.led !== e) begin
            miscompares++;
            $display("FAIL gray_step k=%0d: got %b expected %b", k, io_if.led, e);
         end
      end
   endtask

   task automatic test_mode_press;
      int changes;
      mode_t prev;
      logic [LEDS-1:0] e;
      changes = 0;
      prev = io_if.mode;
      io_if.btn_mode = 1'b1;
      exp_q.push_back(5'd0);
      exp_q.push_back(5'd3);
      exp_q.push_back(5'd4);
      for (int c = 1; c <= 40; c++) begin
         adv(1);
         if (c == 10) io_if.btn_mode = 1'b0;
         if (io_if.mode !== prev) begin
            changes++;
            prev = io_if.mode;
         end
         if (c == 6) begin
            vectors++;
            if (io_if.mode !== 2'd0) begin
               miscompares++;
               $display("FAIL mode_early: got %0d expected 0", io_if.mode);
            end
         end
         if (c == 7) begin
            vectors++;
            if (io_if.mode !== 2'd1) begin
               miscompares++;
               $display("FAIL mode_latency: got %0d expected 1", io_if.mode);
            end
         end
         if (c == 8 || c == 39 || c == 40) begin
            e = exp_q.pop_front();
            vectors++;
            if (io_if.led !== e) begin
               miscompares++;
               $display("FAIL mode_led c=%0d: got %b expected %b", c, io_if.led, e);
            end
         end
      end
      vectors++;
      if (changes !== 1) begin
         miscompares++;
         $display("FAIL mode_press_count: got %0d expected 1", changes);
      end
   endtask

   task automatic test_glitch;
      int changes;
      changes = 0;
      for (int c = 1; c <= 36; c++) begin
         if (c <= 3)       io_if.btn_mode = 1'b1;
         else if (c <= 6)  io_if.btn_mode = 1'b0;
         else if (c <= 26) io_if.btn_mode = (c % 2 == 1);
         else              io_if.btn_mode = 1'b0;
         adv(1);
         if (io_if.mode !== 2'd1) changes++;
      end
      vectors++;
      if (changes !== 0) begin
         miscompares++;
         $display("FAIL glitch_press: got %0d cycles off mode 1 expected 0", changes);
      end
   endtask

   task automatic test_scan;
      int seq [10];
      logic [LEDS-1:0] e;
      logic [LEDS-1:0] prev_e;
      int cur;
      seq = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1};
      adv(4);
      do_press(1'b1, 1'b0);
      vectors++;
      if (io_if.mode !== 2'd2) begin
         miscompares++;
         $display("FAIL scan_enter: got %0d expected 2", io_if.mode);
      end
      for (int k = 0; k < 10; k++) exp_q.push_back(5'b00001 << seq[k]);
      cur = 0;
      prev_e = 5'b00000;
      for (int k = 0; k < 10; k++) begin
         if (k > 0) begin
            adv(8 * k - cur);
            cur = 8 * k;
            vectors++;
            if (io_if.led !== prev_e) begin
               miscompares++;
               $display("FAIL scan_hold k=%0d: got %b expected %b", k, io_if.led, prev_e);
            end
         end
         adv(8 * k + 1 - cur);
         cur = 8 * k + 1;
         e = exp_q.pop_front();
         prev_e = e;
         vectors++;
         if (io_if.led !== e) begin
            miscompares++;
            $display("FAIL scan_step k=%0d: got %b expected %b", k, io_if.led, e);
         end
      end
   endtask

   task automatic test_pause;
      int tries;
      logic [LEDS-1:0] e;
      tries = 0;
      adv(4);
      do begin
         do_press(1'b1, 1'b0);
         tries++;
         if (io_if.mode !== 2'd1) adv(4);
      end while (io_if.mode !== 2'd1 && tries < 4);
      vectors++;
      if (io_if.mode !== 2'd1) begin
         miscompares++;
         $display("FAIL pause_setup: got mode %0d expected 1", io_if.mode);
      end
      adv(35);
      exp_q.push_back(5'b00101);
      do_press(1'b0, 1'b1);
      e = exp_q.pop_front();
      vectors++;
      if (io_if.led !== e) begin
         miscompares++;
         $display("FAIL pause_enter: got %b expected %b", io_if.led, e);
      end
      for (int i = 0; i < 100; i++) begin
         adv(1);
         vectors++;
         if (io_if.led !== 5'b00101) begin
            miscompares++;
            $display("FAIL pause_hold i=%0d: got %b expected %b", i, io_if.led, 5'b00101);
         end
      end
      exp_q.push_back(5'b00110);
      do_press(1'b0, 1'b1);
      adv(6);
      vectors++;
      if (io_if.led !== 5'b00101) begin
         miscompares++;
         $display("FAIL resume_hold: got %b expected %b", io_if.led, 5'b00101);
      end
      adv(1);
      e = exp_q.pop_front();
      vectors++;
      if (io_if.led !== e) begin
         miscompares++;
         $display("FAIL resume_step: got %b expected %b", io_if.led, e);
      end
      // Mode and pause pressed together: both must act.
      do_press(1'b1, 1'b1);
      vectors++;
      if (io_if.mode !== 2'd2) begin
         miscompares++;
         $display("FAIL dual_mode: got %0d expected 2", io_if.mode);
      end
      adv(1);
      vectors++;
      if (io_if.led !== 5'b00001) begin
         miscompares++;
         $display("FAIL dual_clear: got %b expected %b", io_if.led, 5'b00001);
      end
      adv(20);
      vectors++;
      if (io_if.led !== 5'b00001) begin
         miscompares++;
         $display("FAIL dual_paused: got %b expected %b", io_if.led, 5'b00001);
      end
      adv(4);
      do_press(1'b0, 1'b1);
      adv(8);
      vectors++;
      if (io_if.led !== 5'b00001) begin
         miscompares++;
         $display("FAIL unpause_hold: got %b expected %b", io_if.led, 5'b00001);
      end
      adv(1);
      vectors++;
      if (io_if.led !== 5'b00010) begin
         miscompares++;
         $display("FAIL unpause_scan: got %b expected %b", io_if.led, 5'b00010);
      end
   endtask

   task automatic test_mode_wrap;
`ifdef LED_PATTERN_BREATHE_EN
      int ones;
      int zeros;
`endif
      adv(4);
      do_press(1'b1, 1'b0);
`ifdef LED_PATTERN_BREATHE_EN
      vectors++;
      if (io_if.mode !== 2'd3) begin
         miscompares++;
         $display("FAIL breathe_enter: got %0d expected 3", io_if.mode);
      end
      ones = 0;
      zeros = 0;
      adv(1);
      for (int i = 0; i < 64; i++) begin
         adv(1);
         vectors++;
         if (io_if.led === 5'b11111) ones++;
         else if (io_if.led === 5'b00000) zeros++;
         else begin
            miscompares++;
            $display("FAIL breathe_uniform: got %b expected all-equal bits", io_if.led);
         end
      end
      vectors++;
      if (ones == 0 || zeros == 0) begin
         miscompares++;
         $display("FAIL breathe_duty: got ones=%0d zeros=%0d expected both nonzero", ones, zeros);
      end
      adv(4);
      do_press(1'b1, 1'b0);
`endif
      vectors++;
      if (io_if.mode !== 2'd0) begin
         miscompares++;
         $display("FAIL mode_wrap: got %0d expected 0", io_if.mode);
      end
   endtask

   task automatic test_reset_mid;
      adv(4);
      do_press(1'b1, 1'b0);
      adv(4);
      do_press(1'b1, 1'b0);
      vectors++;
      if (io_if.mode !== 2'd2) begin
         miscompares++;
         $display("FAIL reset_setup: got %0d expected 2", io_if.mode);
      end
      adv(20);
      vectors++;
      if (io_if.led !== 5'b00100) begin
         miscompares++;
         $display("FAIL scan_before_reset: got %b expected %b", io_if.led, 5'b00100);
      end
      #2;
      resetn = 1'b0;
      #1;
      vectors++;
      if (io_if.led !== 5'b00000) begin
         miscompares++;
         $display("FAIL async_reset_led: got %b expected %b", io_if.led, 5'b00000);
      end
      vectors++;
      if (io_if.mode !== 2'd0) begin
         miscompares++;
         $display("FAIL async_reset_mode: got %0d expected 0", io_if.mode);
      end
      adv(2);
      vectors++;
      if (io_if.led !== 5'b00000) begin
         miscompares++;
         $display("FAIL reset_hold: got %b expected %b", io_if.led, 5'b00000);
      end
      resetn = 1'b1;
   endtask

   initial begin
      test_reset;
      test_gray;
      test_mode_press;
      test_glitch;
      test_scan;
      test_pause;
      test_mode_wrap;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
